// File: rtl/stoch_pkg.sv
// Shared types and helpers for the stochastic-computing blocks.
// Holds the SNG state enum, default LFSR taps and the stream length.
package stoch_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  // Maximal-length Galois feedback masks for the widths in use
  function automatic logic [31:0] default_taps(input int w);
    case (w)
      4:       return 32'h9;
      10:      return 32'h204;
      default: return 32'hB8;
    endcase
  endfunction

  function automatic int stream_len(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/sc_lfsr.sv
// W-bit Galois LFSR with synchronous load, advance enable
// and a guard that turns an all-zero seed into 1.
module sc_lfsr #(
  parameter int             W    = 8,
  parameter logic [W-1:0]   TAPS = 8'hB8,
  parameter logic [W-1:0]   SEED = 8'h01
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         adv_i,
  output logic [W-1:0] lfsr_o
);

  localparam logic [W-1:0] SEED_NZ =
    (SEED == '0) ? W'(1) : SEED;

  logic [W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i)
      lfsr_d = SEED_NZ;
    else if (adv_i)
      lfsr_d = (lfsr_q >> 1) ^
               (lfsr_q[0] ? TAPS : '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      lfsr_q <= SEED_NZ;
    else
      lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/sng_encoder.sv
// Binary-to-stochastic encoder: one LFSR period per value,
// with exactly v ones among the 2^W-1 emitted bits.
module sng_encoder
  import stoch_pkg::*;
#(
  parameter int           W    = 8,
  parameter logic [W-1:0] TAPS = W'(default_taps(W)),
  parameter logic [W-1:0] SEED = W'(1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         en,
  output logic         bit_out,
  output logic         bit_valid,
  output logic         last,
  output logic         busy
);

  localparam logic [W-1:0] LAST_CNT =
    W'(stream_len(W) - 1);

  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] val_q, val_d;
  logic [W-1:0] lfsr;
  logic         bit_q, bit_d;
  logic         bv_q, bv_d;
  logic         last_q, last_d;
  logic         load, adv;
  logic         fin;

  sc_lfsr #(
    .W    (W),
    .TAPS (TAPS),
    .SEED (SEED)
  ) u_lfsr (
    .clk_i  (clk),
    .rst_ni (rst),
    .load_i (load),
    .adv_i  (adv),
    .lfsr_o (lfsr)
  );

  assign fin = (cnt_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    bit_d   = bit_q;
    bv_d    = 1'b0;
    last_d  = 1'b0;
    load    = 1'b0;
    adv     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          val_d   = in_data;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (en) begin
          bit_d  = (lfsr <= val_q);
          bv_d   = 1'b1;
          last_d = fin;
          adv    = 1'b1;
          cnt_d  = cnt_q + W'(1);
          if (fin) begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      val_q   <= '0;
      bit_q   <= 1'b0;
      bv_q    <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      bit_q   <= bit_d;
      bv_q    <= bv_d;
      last_q  <= last_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign bit_out   = bit_q;
  assign bit_valid = bv_q;
  assign last      = last_q;

endmodule

// File: tb/tb_sng_encoder.sv
// Scoreboard bench for sng_encoder: a SEED=1 and a SEED=0
// instance share stimulus and are checked against one model.
module tb_sng_encoder;

  typedef struct packed {
    logic b;
    logic l;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       en;
  logic       rdy0, bo0, bv0, l0, busy0;
  logic       rdy1, bo1, bv1, l1, busy1;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q[2][$];
  int   vq[2][$];
  int   nbits[2];
  int   nones[2];
  bit   running[2];
  bit   prev_last[2];
  bit   en_rand = 1'b0;

  always #5 clk = ~clk;

  sng_encoder u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (rdy0),
    .in_data   (in_data),
    .en        (en),
    .bit_out   (bo0),
    .bit_valid (bv0),
    .last      (l0),
    .busy      (busy0)
  );

  sng_encoder #(.SEED(8'h00)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (rdy1),
    .in_data   (in_data),
    .en        (en),
    .bit_out   (bo1),
    .bit_valid (bv1),
    .last      (l1),
    .busy      (busy1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference stream: walk the Galois sequence from 1
  task automatic push_stream(input int v);
    logic [7:0] l;
    l = 8'h01;
    for (int i = 0; i < 255; i++) begin
      for (int d = 0; d < 2; d++)
        q[d].push_back('{b: (l <= v[7:0]), l: (i == 254)});
      l = (l >> 1) ^ (l[0] ? 8'hB8 : 8'h00);
    end
    for (int d = 0; d < 2; d++)
      vq[d].push_back(v);
  endtask

  task automatic mon(input int id, input logic b,
                     input logic v, input logic l,
                     input logic r);
    exp_t e;
    if (prev_last[id])
      chk($sformatf("gap%0d", id), v, 0);
    prev_last[id] = v && l;
    if (running[id] && !l)
      chk($sformatf("rdy_run%0d", id), r, 0);
    if (!v) begin
      chk($sformatf("last_idle%0d", id), l, 0);
    end else if (q[id].size() == 0) begin
      chk($sformatf("sb_empty%0d", id), 1, 0);
    end else begin
      e = q[id].pop_front();
      chk($sformatf("bit%0d", id), b, e.b);
      chk($sformatf("last%0d", id), l, e.l);
      nbits[id]++;
      nones[id] += int'(b);
      if (e.l) begin
        chk($sformatf("len%0d", id), nbits[id], 255);
        chk($sformatf("ones%0d", id), nones[id],
            vq[id].pop_front());
        nbits[id]   = 0;
        nones[id]   = 0;
        running[id] = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      mon(0, bo0, bv0, l0, rdy0);
      mon(1, bo1, bv1, l1, rdy1);
    end
  end

  always @(posedge clk) begin
    #1;
    en = en_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send(input int v, input bit hold,
                      input bit b2b);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = v[7:0];
    #1;
    while (!rdy0 && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 3000) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    if (b2b)
      chk("b2b_last", l0, 1);
    push_stream(v);
    @(posedge clk);
    running[0] = 1'b1;
    running[1] = 1'b1;
    #1;
    if (!hold)
      in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q[0].size() != 0 || q[1].size() != 0 ||
            running[0] || running[1]) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000)
      chk("drain_timeout", 0, 1);
  endtask

  task automatic flush();
    for (int d = 0; d < 2; d++) begin
      q[d].delete();
      vq[d].delete();
      nbits[d]     = 0;
      nones[d]     = 0;
      running[d]   = 1'b0;
      prev_last[d] = 1'b0;
    end
  endtask

  initial begin
    int n;
    flush();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    en       = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_bit", bo0, 0);
    chk("rst_valid", bv0, 0);
    chk("rst_last", l0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_bit1", bo1, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", rdy0, 1);
    chk("rdy_after_rst1", rdy1, 1);

    send(0, 0, 0);
    wait_idle();
    send(255, 0, 0);
    wait_idle();
    send(128, 0, 0);
    wait_idle();
    send(1, 0, 0);
    wait_idle();

    en_rand = 1'b1;
    send(100, 0, 0);
    wait_idle();
    en_rand = 1'b0;

    send(50, 1, 0);
    send(200, 0, 1);
    wait_idle();

    send(77, 0, 0);
    n = 0;
    while (nbits[0] < 37 && n < 2000) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (n >= 2000)
      chk("bit37_timeout", 0, 1);
    rst = 1'b0;
    #1;
    chk("abort_bit", bo0, 0);
    chk("abort_valid", bv0, 0);
    chk("abort_last", l0, 0);
    chk("abort_busy", busy0, 0);
    chk("abort_busy1", busy1, 0);
    flush();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("abort_rdy", rdy0, 1);
    send(77, 0, 0);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sng_encoder.md
Name: sng_encoder

Overview:
- Binary-to-stochastic number generator (SNG). The front end that produces the unipolar bitstreams consumed by the stochastic FSM elements (stanh-style counters) in stochckts.
- Accepts a W-bit magnitude v through a valid/ready handshake.
- Emits exactly one LFSR period, 2^W-1 bits, of which exactly v are 1, so P(1) = v/(2^W-1).
- Output stream can be stalled with a clock enable.

Parameters:
- W, 8, value width and LFSR width.
- TAPS, 8'hB8, Galois LFSR feedback mask; must be maximal-length for W (8'hB8 = x^8+x^6+x^5+x^4+1).
- SEED, 8'h01, LFSR start value; a value of 0 is replaced by 1.

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, asynchronous active-low reset.
- in_valid, in, 1, in_data is valid.
- in_ready, out, 1, block can accept a value.
- in_data, in, W, magnitude v, unsigned.
- en, in, 1, stream advance enable (downstream stall when 0).
- bit_out, out, 1, stochastic bit.
- bit_valid, out, 1, bit_out is a stream bit this cycle.
- last, out, 1, qualifies the final bit of the stream.
- busy, out, 1, stream in progress.

Behaviour:
- Reset (rst=0, async): state=IDLE; lfsr=SEED (or 1 if SEED=0); cnt=0; val=0; bit_out=0; bit_valid=0; last=0. in_ready=1 once rst is released.
- States: IDLE and RUN. busy=(state==RUN). in_ready=(state==IDLE), combinational from state.
- IDLE:
  - On in_valid&&in_ready: val<=in_data, lfsr<=SEED, cnt<=0, go to RUN.
  - in_data is ignored when in_valid=0.
- RUN, en=1 cycle:
  - Registered outputs: bit_out<=(lfsr<=val) as an unsigned W-bit compare; bit_valid<=1; last<=(cnt==2^W-2).
  - Advance the Galois LFSR: lfsr<=(lfsr>>1)^(lfsr[0]?TAPS:0).
  - cnt<=cnt+1.
  - If cnt==2^W-2: go to IDLE with cnt<=0.
- RUN, en=0 cycle: lfsr, cnt and state hold; bit_valid<=0; last<=0; bit_out holds its value.
- Latency: the first bit_valid comes 1 cycle after the first RUN cycle with en=1, so 2 cycles after the handshake if en is held high.
- Each bit is registered one cycle after its enabled RUN cycle.
- Exactness: the LFSR visits every value 1..2^W-1 exactly once per stream, so the ones count equals v exactly.
  - v=0 gives all zeros.
  - v=2^W-1 gives all ones.
- Back-to-back streams:
  - The cycle where last=1 is registered, the state is already IDLE, so in_ready=1 in that same cycle.
  - The gap between streams is one bit_valid=0 cycle minimum.
- en=0 in IDLE has no effect. The handshake is independent of en.
- bit_valid and last are 0 in IDLE, except in the final-bit cycle described above.
- Reset mid-stream: the stream aborts immediately; no last is produced; the next accepted value restarts from SEED.
- cnt width is W; it never wraps because it clears at 2^W-2.

Decomposition:
- Shared package stoch_pkg holds:
  - the state enum (IDLE, RUN);
  - the default TAPS per width (W=8: 8'hB8; W=4: 4'h9; W=10: 10'h204);
  - the stream length function 2^W-1.
- One natural sub-module, sc_lfsr: W-bit Galois LFSR with load, seed, advance enable and nonzero-seed guard. It is reused by future SNG/correlation blocks.
- Comparator and FSM stay in sng_encoder.

Test Plan:
- v=0, en=1 -> 255 bit_valid pulses, all bit_out=0, last on pulse 255 only, in_ready low throughout RUN.
- v=255 -> 255 ones; v=128 -> exactly 128 ones; v=1 -> exactly one 1, which occurs on the cycle where lfsr==1.
- v=100 with en toggled 1,0,0,1 pseudo-randomly -> exactly 255 valid bits, 100 ones, and the bit sequence is identical to the en=1 run.
- Two values (50 then 200) offered back-to-back with in_valid held -> second accepted in the last=1 cycle, stream counts 50 and 200, one idle gap.
- rst pulsed low at bit 37 of a v=77 stream -> outputs 0 asynchronously, in_ready=1 after release, next stream v=77 gives 77 ones from bit 1.
- SEED=0 parameter build -> behaves identically to SEED=1; no lockup, 255 bits per stream.
